register_bank_inc: RTL

Parametrised bank of clocked increment/decrement registers, the successor to the single latch-based incrementing register. It holds CHANNELS independent N-bit registers (program counter, stack pointer, address pointers) behind one shared bus port. Each register can be loaded, incremented or decremented, with selectable wrap or saturate arithmetic and a per-channel sticky overflow flag. All state is flip-flop based on a single clock.

---
 rtl/register_bank_inc.sv | 92 +++++++++
 1 files changed

// File: rtl/register_bank_inc.sv
// rtl/register_bank_inc.sv - bank of CHANNELS N-bit load/increment/decrement registers
// with wrap or saturate arithmetic and per-channel sticky overflow flags behind one shared port.
module register_bank_inc #(
    parameter int N        = 8,
    parameter int CHANNELS = 4,
    parameter int SATURATE = 0,
    localparam int SW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [SW-1:0] sel,
    input  logic [N-1:0]  data_in,
    input  logic          write,
    input  logic          increment,
    input  logic          decrement,
    input  logic          read,
    output logic [N-1:0]  data_out,
    output logic          flag_out,
    output logic          zero
);

    logic [N-1:0]        regs [CHANNELS];
    logic [CHANNELS-1:0] flags;

    logic [N-1:0] cur_val;
    logic         cur_flag;
    logic         sel_valid;
    logic [N-1:0] next_val;
    logic         ovf;

    // Explicit mux so an out-of-range sel reads as an empty channel instead of indexing past the array.
    always_comb begin
        cur_val   = '0;
        cur_flag  = 1'b0;
        sel_valid = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (sel == SW'(i)) begin
                cur_val   = regs[i];
                cur_flag  = flags[i];
                sel_valid = 1'b1;
            end
        end
    end

    always_comb begin
        next_val = cur_val;
        ovf      = 1'b0;
        if (increment && !decrement) begin
            if (cur_val == {N{1'b1}}) begin
                ovf      = 1'b1;
                next_val = (SATURATE != 0) ? cur_val : '0;
            end else begin
                next_val = cur_val + N'(1);
            end
        end else if (decrement && !increment) begin
            if (cur_val == '0) begin
                ovf      = 1'b1;
                next_val = (SATURATE != 0) ? cur_val : {N{1'b1}};
            end else begin
                next_val = cur_val - N'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                regs[i] <= '0;
            end
            flags <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (sel == SW'(i)) begin
                    if (write) begin
                        regs[i]  <= data_in;
                        flags[i] <= 1'b0;
                    end else begin
                        regs[i] <= next_val;
                        if (ovf) begin
                            flags[i] <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign data_out = read ? cur_val : '0;
    assign flag_out = read & cur_flag;
    assign zero     = sel_valid & (cur_val == '0);

endmodule
